vx_req_credit_sched: RTL and testbench
======================================

Name: VX_req_credit_sched

Overview:
- Credit-based round-robin request scheduler that shares one memory or cache request port among NUM_REQS requesters.
- Each requester may have at most MAX_PENDING requests outstanding. A credit is consumed when a request is accepted and returned when the matching response is delivered.
- The requester index is appended to the outgoing tag. Responses are steered back to their requester by decoding that index.
- Sits between the core-side memory units and a cache or memory bank input. Adds flow control that plain arbitration lacks, plus a drain/idle facility for fences and flushes.

Parameters:
- NUM_REQS, 4: number of requesters; must be ≥ 2.
- DATAW, 64: opaque request payload width (addr/rw/byteen/data packed by the caller).
- RSP_DATAW, 32: opaque response payload width.
- TAG_IN_WIDTH, 8: requester-side tag width.
- MAX_PENDING, 4: outstanding-request limit per requester; must be ≥ 1.
- Derived (localparam) LOG_NUM_REQS = CLOG2(NUM_REQS).
- Derived (localparam) TAG_OUT_WIDTH = TAG_IN_WIDTH + LOG_NUM_REQS.
- Derived (localparam) CNTW = CLOG2(MAX_PENDING+1).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- drain  in  1  when high, no new grants are issued.
- req_valid_in  in  NUM_REQS  per-requester request valid.
- req_data_in  in  NUM_REQS×DATAW  per-requester payload.
- req_tag_in  in  NUM_REQS×TAG_IN_WIDTH  per-requester tag.
- req_ready_in  out  NUM_REQS  per-requester accept.
- req_valid_out  out  1  registered request valid.
- req_data_out  out  DATAW  registered payload.
- req_tag_out  out  TAG_OUT_WIDTH  {req_tag_in[g], g}, with requester index in bits [LOG_NUM_REQS-1:0].
- req_ready_out  in  1  downstream accept.
- rsp_valid_in  in  1  response valid.
- rsp_data_in  in  RSP_DATAW  response payload.
- rsp_tag_in  in  TAG_OUT_WIDTH  response tag (index in low bits).
- rsp_ready_in  out  1  = rsp_ready_out[sel].
- rsp_valid_out  out  NUM_REQS  one-hot: bit sel = rsp_valid_in.
- rsp_data_out  out  RSP_DATAW  broadcast rsp_data_in.
- rsp_tag_out  out  TAG_IN_WIDTH  rsp_tag_in[TAG_OUT_WIDTH-1:LOG_NUM_REQS].
- rsp_ready_out  in  NUM_REQS  per-requester response accept.
- idle  out  1  no outstanding or buffered requests.

Behaviour:
- Reset values (async, immediate):
  - req_valid_out=0, req_data_out=0, req_tag_out=0.
  - All pending counters = 0.
  - Round-robin pointer = NUM_REQS-1, so requester 0 has top priority first.
  - idle=1.
- Eligibility: eligible[i] = req_valid_in[i] & (pending[i] < MAX_PENDING) & !drain.
- Load condition: load = !req_valid_out | req_ready_out. This gives a one-entry elastic output register and full throughput, 1 grant/cycle.
- Grant: the first eligible index scanning from ptr+1 upward, wrapping modulo NUM_REQS.
  - req_ready_in[g] = load & eligible[g], one-hot or zero.
  - req_ready_in must not depend on req_ready_in outputs; no combinational loops.
  - On a grant, the register loads payload and tag at the next edge, req_valid_out=1, ptr←g.
  - Without a grant: if load, req_valid_out←0; otherwise hold.
- Latency: request visible at output 1 cycle after acceptance.
- Output stability: req_valid_out/data/tag are stable while req_valid_out & !req_ready_out.
- Response path is purely combinational, 0 latency:
  - sel = rsp_tag_in[LOG_NUM_REQS-1:0].
  - Response fires when rsp_valid_in & rsp_ready_in.
  - sel ≥ NUM_REQS (non-power-of-2 NUM_REQS) is illegal and flagged by an assertion.
- Counters: pending[i] += (grant to i) − (response fire for i).
  - Simultaneous grant and response for the same i: net unchanged.
  - Counter never exceeds MAX_PENDING; enforced by eligibility.
  - Response fire with pending[sel]=0: counter stays 0 and a simulation assertion fires.
- Full credit: pending[i]=MAX_PENDING forces req_ready_in[i]=0 even if the output is free. The next response for i re-enables i in the following cycle; the credit check uses registered counters.
- Drain:
  - While drain=1, no grants occur; the buffered request and responses still complete.
  - Deasserting drain resumes arbitration from the current ptr.
- idle = !req_valid_out & (all pending == 0), registered-state based.
- Reset mid-operation: all credits and the buffered request are discarded. Downstream must also be reset, or responses will underflow.

Test Plan:
- Reset then single request: req_valid_in=4'b0001, tag 0x12 -> req_ready_in[0]=1 in that cycle; next cycle req_valid_out=1, req_tag_out=0x48 ({0x12,2'b00}); pending[0]=1; idle=0.
- Round-robin: all 4 valid, req_ready_out=1, responses returned each cycle -> grant order 0,1,2,3,0,… one per cycle, with no repeat while another requester is eligible.
- Credit limit: only req 1 valid, MAX_PENDING=4, no responses -> 4 grants, then req_ready_in[1]=0. Response tag {x,2'b01} fires -> req_ready_in[1]=1 the cycle after.
- Backpressure: req_ready_out=0 with output full -> req_ready_in all 0 and output data held. Release -> buffered request retires and a new grant occurs in the same cycle.
- Simultaneous: grant and response for req 2 in the same cycle at pending=2 -> pending stays 2. Response tag 0x0E with rsp_ready_out=4'b0100 -> rsp_valid_out=4'b0100, rsp_tag_out=0x03, rsp_ready_in=1.
- Drain: drain=1 with 3 outstanding -> no grants; idle rises the cycle after the last response fires. Async reset asserted mid-burst -> outputs 0 and idle=1 immediately.

Source files
------------

// File: rtl/vx_req_credit_sched.sv
// Credit-based round-robin request scheduler.
// NUM_REQS requesters share one downstream request port. Each requester may
// have at most MAX_PENDING requests in flight. The requester index rides in
// the low bits of the outgoing tag and steers the response back.
module vx_req_credit_sched #(
  parameter int NUM_REQS     = 4,
  parameter int DATAW        = 64,
  parameter int RSP_DATAW    = 32,
  parameter int TAG_IN_WIDTH = 8,
  parameter int MAX_PENDING  = 4,
  localparam int LOG_NUM_REQS  = $clog2(NUM_REQS),
  localparam int TAG_OUT_WIDTH = TAG_IN_WIDTH + LOG_NUM_REQS,
  localparam int CNTW          = $clog2(MAX_PENDING + 1)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   drain,
  input  logic [NUM_REQS-1:0]                    req_valid_in,
  input  logic [NUM_REQS-1:0][DATAW-1:0]         req_data_in,
  input  logic [NUM_REQS-1:0][TAG_IN_WIDTH-1:0]  req_tag_in,
  output logic [NUM_REQS-1:0]                    req_ready_in,
  output logic                                   req_valid_out,
  output logic [DATAW-1:0]                       req_data_out,
  output logic [TAG_OUT_WIDTH-1:0]               req_tag_out,
  input  logic                                   req_ready_out,
  input  logic                                   rsp_valid_in,
  input  logic [RSP_DATAW-1:0]                   rsp_data_in,
  input  logic [TAG_OUT_WIDTH-1:0]               rsp_tag_in,
  output logic                                   rsp_ready_in,
  output logic [NUM_REQS-1:0]                    rsp_valid_out,
  output logic [RSP_DATAW-1:0]                   rsp_data_out,
  output logic [TAG_IN_WIDTH-1:0]                rsp_tag_out,
  input  logic [NUM_REQS-1:0]                    rsp_ready_out,
  output logic                                   idle
);

  logic                     req_valid_q, req_valid_d;
  logic [DATAW-1:0]         req_data_q, req_data_d;
  logic [TAG_OUT_WIDTH-1:0] req_tag_q, req_tag_d;
  logic [LOG_NUM_REQS-1:0]  ptr_q, ptr_d;
  logic [CNTW-1:0]          pending_q [NUM_REQS];
  logic [CNTW-1:0]          pending_d [NUM_REQS];

  logic                     load;
  logic [NUM_REQS-1:0]      eligible;
  logic                     found;
  logic                     grant;
  logic [LOG_NUM_REQS-1:0]  grant_idx;
  logic [NUM_REQS-1:0]      grant_oh;
  logic [LOG_NUM_REQS-1:0]  rsp_sel;
  logic                     rsp_sel_hit;
  logic [NUM_REQS-1:0]      rsp_fire;
  logic                     underflow;

  // Eligibility uses registered credit counts only, so ready never loops back.
  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      eligible[i] = req_valid_in[i] & (pending_q[i] < CNTW'(MAX_PENDING)) & ~drain;
    end
  end

  // Round-robin pick: first eligible index after ptr, wrapping.
  always_comb begin
    load      = ~req_valid_q | req_ready_out;
    found     = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= NUM_REQS; k++) begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (!found && eligible[i] &&
            ((int'(ptr_q) + k == i) || (int'(ptr_q) + k == i + NUM_REQS))) begin
          found     = 1'b1;
          grant_idx = LOG_NUM_REQS'(i);
        end
      end
    end
    grant    = load & found;
    grant_oh = '0;
    if (grant) grant_oh[grant_idx] = 1'b1;
  end

  // Response steering is purely combinational on the tag's index bits.
  always_comb begin
    rsp_sel       = rsp_tag_in[LOG_NUM_REQS-1:0];
    rsp_sel_hit   = 1'b0;
    rsp_ready_in  = 1'b0;
    rsp_valid_out = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (rsp_sel == LOG_NUM_REQS'(i)) begin
        rsp_sel_hit      = 1'b1;
        rsp_ready_in     = rsp_ready_out[i];
        rsp_valid_out[i] = rsp_valid_in;
      end
    end
    rsp_fire = rsp_valid_out & {NUM_REQS{rsp_ready_in}};
  end

  // Credit counters: +1 on grant, -1 on response fire, clamped at zero.
  always_comb begin
    underflow = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      pending_d[i] = pending_q[i];
      underflow    = underflow | (rsp_fire[i] & (pending_q[i] == '0));
      case ({grant_oh[i], rsp_fire[i]})
        2'b10:   pending_d[i] = pending_q[i] + CNTW'(1);
        2'b01:   if (pending_q[i] != '0) pending_d[i] = pending_q[i] - CNTW'(1);
        default: pending_d[i] = pending_q[i];
      endcase
    end
  end

  // One-entry elastic output register; holds while stalled downstream.
  always_comb begin
    req_valid_d = req_valid_q;
    req_data_d  = req_data_q;
    req_tag_d   = req_tag_q;
    ptr_d       = ptr_q;
    if (grant) begin
      req_valid_d = 1'b1;
      req_data_d  = req_data_in[grant_idx];
      req_tag_d   = {req_tag_in[grant_idx], grant_idx};
      ptr_d       = grant_idx;
    end else if (load) begin
      req_valid_d = 1'b0;
    end
  end

  // Idle when nothing is buffered and no credit is in use.
  always_comb begin
    idle = ~req_valid_q;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (pending_q[i] != '0) idle = 1'b0;
    end
  end

  // State registers; ptr resets to the last index so requester 0 wins first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_valid_q <= 1'b0;
      req_data_q  <= '0;
      req_tag_q   <= '0;
      ptr_q       <= LOG_NUM_REQS'(NUM_REQS - 1);
      for (int i = 0; i < NUM_REQS; i++) pending_q[i] <= '0;
    end else begin
      req_valid_q <= req_valid_d;
      req_data_q  <= req_data_d;
      req_tag_q   <= req_tag_d;
      ptr_q       <= ptr_d;
      for (int i = 0; i < NUM_REQS; i++) pending_q[i] <= pending_d[i];
    end
  end

  assign req_ready_in  = grant_oh;
  assign req_valid_out = req_valid_q;
  assign req_data_out  = req_data_q;
  assign req_tag_out   = req_tag_q;
  assign rsp_data_out  = rsp_data_in;
  assign rsp_tag_out   = rsp_tag_in[TAG_OUT_WIDTH-1:LOG_NUM_REQS];

  // Response index must name a real requester, and must have a credit to return.
  a_rsp_sel_legal: assert property (@(posedge clk) disable iff (reset)
    rsp_valid_in |-> rsp_sel_hit);
  a_rsp_no_underflow: assert property (@(posedge clk) disable iff (reset)
    !underflow);

endmodule

// File: tb/tb_vx_req_credit_sched.sv
// Directed scenarios followed by randomized traffic, all checked against a
// cycle-level reference model of the credit scheduler.
module tb_vx_req_credit_sched;
  localparam int N   = 4;
  localparam int DW  = 64;
  localparam int RW  = 32;
  localparam int TW  = 8;
  localparam int MP  = 4;
  localparam int LG  = 2;
  localparam int TOW = TW + LG;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  drain;
  logic [N-1:0]          req_valid_in;
  logic [N-1:0][DW-1:0]  req_data_in;
  logic [N-1:0][TW-1:0]  req_tag_in;
  logic [N-1:0]          req_ready_in;
  logic                  req_valid_out;
  logic [DW-1:0]         req_data_out;
  logic [TOW-1:0]        req_tag_out;
  logic                  req_ready_out;
  logic                  rsp_valid_in;
  logic [RW-1:0]         rsp_data_in;
  logic [TOW-1:0]        rsp_tag_in;
  logic                  rsp_ready_in;
  logic [N-1:0]          rsp_valid_out;
  logic [RW-1:0]         rsp_data_out;
  logic [TW-1:0]         rsp_tag_out;
  logic [N-1:0]          rsp_ready_out;
  logic                  idle;

  always #5 clk = ~clk;

  vx_req_credit_sched #(.NUM_REQS(N), .DATAW(DW), .RSP_DATAW(RW),
                        .TAG_IN_WIDTH(TW), .MAX_PENDING(MP)) dut (
    .clk(clk), .reset(reset), .drain(drain),
    .req_valid_in(req_valid_in), .req_data_in(req_data_in), .req_tag_in(req_tag_in),
    .req_ready_in(req_ready_in), .req_valid_out(req_valid_out),
    .req_data_out(req_data_out), .req_tag_out(req_tag_out),
    .req_ready_out(req_ready_out), .rsp_valid_in(rsp_valid_in),
    .rsp_data_in(rsp_data_in), .rsp_tag_in(rsp_tag_in), .rsp_ready_in(rsp_ready_in),
    .rsp_valid_out(rsp_valid_out), .rsp_data_out(rsp_data_out),
    .rsp_tag_out(rsp_tag_out), .rsp_ready_out(rsp_ready_out), .idle(idle)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  int             m_pend [N];
  int             m_ptr;
  bit             m_vld;
  logic [DW-1:0]  m_data;
  logic [TOW-1:0] m_tag;
  int             m_g;
  bit             m_load;
  bit             m_fire;
  int             m_sel;
  logic [DW-1:0]  g_data;
  logic [TOW-1:0] g_tag;
  logic [TOW-1:0] dq[$];

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_vld = 0; m_data = '0; m_tag = '0; m_ptr = N - 1;
    for (int i = 0; i < N; i++) m_pend[i] = 0;
    dq.delete();
  endtask

  task automatic clear_inputs();
    drain = 0; req_valid_in = '0; req_data_in = '0; req_tag_in = '0;
    req_ready_out = 1; rsp_valid_in = 0; rsp_data_in = '0; rsp_tag_in = '0;
    rsp_ready_out = '1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    #1;
    chk("rst_valid", 64'(req_valid_out), 64'd0);
    chk("rst_data", req_data_out, 64'd0);
    chk("rst_tag", 64'(req_tag_out), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    @(posedge clk); #1;
    reset = 0;
    model_reset();
  endtask

  // Before the edge: predict the grant and check the combinational outputs.
  task automatic settle_check();
    logic [N-1:0] exp_rdy;
    int total_sum;
    #1;
    m_load = !m_vld || req_ready_out;
    m_g = -1;
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (m_g < 0 && req_valid_in[i] && m_pend[i] < MP && !drain) m_g = i;
    end
    if (!m_load) m_g = -1;
    exp_rdy = (m_g >= 0) ? N'(1 << m_g) : '0;
    chk("req_ready_in", 64'(req_ready_in), 64'(exp_rdy));
    if (m_g >= 0) begin
      g_data = req_data_in[m_g];
      g_tag  = TOW'(int'(req_tag_in[m_g]) * N + m_g);
    end
    m_sel = int'(rsp_tag_in) % N;
    chk("rsp_valid_out", 64'(rsp_valid_out), rsp_valid_in ? 64'(1 << m_sel) : 64'd0);
    chk("rsp_ready_in", 64'(rsp_ready_in), 64'(rsp_ready_out[m_sel]));
    if (rsp_valid_in) begin
      chk("rsp_tag_out", 64'(rsp_tag_out), 64'(int'(rsp_tag_in) / N));
      chk("rsp_data_out", 64'(rsp_data_out), 64'(rsp_data_in));
    end
    m_fire = rsp_valid_in && rsp_ready_out[m_sel];
    if (m_vld && req_ready_out) dq.push_back(m_tag);
    total_sum = 0;
  endtask

  // After the edge: advance the model and check registered outputs.
  task automatic clock_check();
    int s;
    @(posedge clk); #1;
    if (m_fire && m_pend[m_sel] > 0) m_pend[m_sel]--;
    if (m_g >= 0) begin
      m_pend[m_g]++;
      m_vld = 1; m_data = g_data; m_tag = g_tag; m_ptr = m_g;
    end else if (m_load) begin
      m_vld = 0;
    end
    chk("req_valid_out", 64'(req_valid_out), 64'(m_vld));
    if (m_vld) begin
      chk("req_data_out", req_data_out, m_data);
      chk("req_tag_out", 64'(req_tag_out), 64'(m_tag));
    end
    s = 0;
    for (int i = 0; i < N; i++) s += m_pend[i];
    chk("idle", 64'(idle), 64'(!m_vld && s == 0));
  endtask

  task automatic step();
    settle_check();
    clock_check();
  endtask

  task automatic rand_payload();
    for (int i = 0; i < N; i++) begin
      req_data_in[i] = {$urandom, $urandom};
      req_tag_in[i]  = TW'($urandom);
    end
  endtask

  initial begin
    // Reset then a single request from requester 0
    do_reset();
    rand_payload();
    req_valid_in = 4'b0001; req_tag_in[0] = 8'h12;
    settle_check();
    chk("single_ready", 64'(req_ready_in), 64'h1);
    clock_check();
    chk("single_tag", 64'(req_tag_out), 64'h048);
    chk("single_idle", 64'(idle), 64'd0);
    req_valid_in = '0;
    step();
    rsp_valid_in = 1; rsp_tag_in = 10'h048; rsp_data_in = $urandom;
    step();
    rsp_valid_in = 0;
    step();

    // Round-robin with all requesters valid, responses returned each cycle
    do_reset();
    req_valid_in = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      rand_payload();
      rsp_valid_in = req_valid_out; rsp_tag_in = req_tag_out; rsp_data_in = $urandom;
      settle_check();
      chk("rr_order", 64'(req_ready_in), 64'(1 << (k % N)));
      clock_check();
    end

    // Credit limit on requester 1
    do_reset();
    req_valid_in = 4'b0010;
    for (int k = 0; k < 6; k++) begin
      rand_payload();
      settle_check();
      chk("credit_ready", 64'(req_ready_in), (k < MP) ? 64'h2 : 64'h0);
      clock_check();
    end
    rsp_valid_in = 1; rsp_tag_in = 10'h0CD; rsp_data_in = $urandom;
    settle_check();
    chk("credit_ret_same", 64'(req_ready_in), 64'h0);
    clock_check();
    rsp_valid_in = 0;
    settle_check();
    chk("credit_ret_next", 64'(req_ready_in), 64'h2);
    clock_check();

    // Backpressure holds the buffered request
    do_reset();
    req_valid_in = 4'b1111; req_ready_out = 0;
    rand_payload();
    step();
    rand_payload();
    settle_check();
    chk("bp_ready", 64'(req_ready_in), 64'h0);
    clock_check();
    req_ready_out = 1;
    rand_payload();
    settle_check();
    chk("bp_release", 64'(req_ready_in), 64'h2);
    clock_check();

    // Simultaneous grant and response on requester 2
    do_reset();
    req_valid_in = 4'b0100;
    step(); step();
    rsp_valid_in = 1; rsp_tag_in = 10'h00E; rsp_ready_out = 4'b0100; rsp_data_in = $urandom;
    settle_check();
    chk("sim_rsp_valid", 64'(rsp_valid_out), 64'h4);
    chk("sim_rsp_tag", 64'(rsp_tag_out), 64'h03);
    chk("sim_rsp_ready", 64'(rsp_ready_in), 64'h1);
    chk("sim_req_ready", 64'(req_ready_in), 64'h4);
    clock_check();
    rsp_valid_in = 0; rsp_ready_out = '1;
    for (int k = 0; k < 3; k++) begin
      settle_check();
      chk("sim_credit", 64'(req_ready_in), (k < 2) ? 64'h4 : 64'h0);
      clock_check();
    end

    // Drain with three outstanding
    do_reset();
    req_valid_in = 4'b0111;
    step(); step(); step();
    drain = 1; req_valid_in = 4'b1111;
    step();
    chk("drain_busy", 64'(idle), 64'd0);
    for (int s = 0; s < 3; s++) begin
      rsp_valid_in = 1; rsp_tag_in = TOW'(8'h5A * N + s); rsp_data_in = $urandom;
      settle_check();
      chk("drain_no_grant", 64'(req_ready_in), 64'h0);
      clock_check();
    end
    rsp_valid_in = 0;
    chk("drain_idle", 64'(idle), 64'd1);
    drain = 0;
    settle_check();
    chk("drain_resume", 64'(req_ready_in), 64'h8);
    clock_check();

    // Asynchronous reset in the middle of a burst
    req_valid_in = 4'b1111;
    step(); step(); step();
    reset = 1;
    #1;
    chk("arst_valid", 64'(req_valid_out), 64'd0);
    chk("arst_data", req_data_out, 64'd0);
    chk("arst_tag", 64'(req_tag_out), 64'd0);
    chk("arst_idle", 64'(idle), 64'd1);
    @(posedge clk); #1;
    reset = 0;
    model_reset();
    clear_inputs();

    // Randomized traffic with an in-order downstream
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rand_payload();
      req_valid_in  = N'($urandom);
      req_ready_out = ($urandom % 4) != 0;
      drain         = ($urandom % 16) == 0;
      if (dq.size() > 0 && ($urandom % 2) == 1) begin
        rsp_valid_in  = 1;
        rsp_tag_in    = dq[0];
        rsp_ready_out = N'($urandom);
      end else begin
        rsp_valid_in  = 0;
        rsp_tag_in    = TOW'($urandom);
        rsp_ready_out = N'($urandom);
      end
      rsp_data_in = $urandom;
      settle_check();
      if (m_fire) void'(dq.pop_front());
      clock_check();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
